id_ex_ctrl_pipe_reg: RTL

Parametrised ID/EX pipeline register. It carries the full decoded control bundle, operand data and register specifiers from the decode stage to the execute stage. It supports hazard-unit stall (hold) and flush (bubble insertion), a per-stage valid bit, and a gated store-enable output. Two saturating counters track bubbles and stall cycles for pipeline debug.

---
 rtl/id_ex_ctrl_pipe_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_ex_ctrl_pipe_reg.sv
// ID/EX pipeline register: carries the decoded control bundle, operands and
// register specifiers into execute, with hold (stall), bubble insertion
// (flush), a gated store enable and saturating bubble/stall debug counters.
module id_ex_ctrl_pipe_reg #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned SW_BIT = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic              clr_counts,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_write,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [CNT_W-1:0]  bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0]  stl_cnt_q, stl_cnt_d;

    logic bubble_evt;
    logic stall_evt;

    // Edge qualifiers: a bubble is captured on flush or on a load of an empty slot.
    assign bubble_evt = flush | (~stall & ~id_valid);
    assign stall_evt  = stall & ~flush;

    // Pipeline next state: flush beats stall beats load; flush leaves data fields alone.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall) begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? id_ctrl : '0;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
        end
    end

    // Debug counters: clear wins over increment, increments stop at all-ones.
    always_comb begin
        bub_cnt_d = bub_cnt_q;
        stl_cnt_d = stl_cnt_q;
        if (clr_counts) begin
            bub_cnt_d = '0;
            stl_cnt_d = '0;
        end else begin
            if (bubble_evt && (bub_cnt_q != CNT_MAX)) begin
                bub_cnt_d = bub_cnt_q + CNT_W'(1);
            end
            if (stall_evt && (stl_cnt_q != CNT_MAX)) begin
                stl_cnt_d = stl_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            bub_cnt_q <= '0;
            stl_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            bub_cnt_q <= bub_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign bubble_count = bub_cnt_q;
    assign stall_count  = stl_cnt_q;

    // Store enable decoded from registered state only; a bubble never stores.
    assign ex_mem_write = ctrl_q[SW_BIT] & valid_q;

endmodule
